// File: rtl/mult_eval_pkg.sv
// Shared types and helpers for the exhaustive multiplier sweep scorer.
package mult_eval_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int unsigned SETTLE_W = 4;

  function automatic int unsigned pair_count(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

  function automatic int unsigned count_width(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Exact product; callers narrow to 2*WIDTH, which always holds the full result.
  function automatic logic [63:0] golden_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

endpackage

// File: rtl/mult_sweep_counter.sv
// Pair index and settle-wait counter for the sweep; flags last pair and settle completion.
module mult_sweep_counter
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               settle_en,
  input  logic               step,
  output logic [2*WIDTH-1:0] idx,
  output logic               last_c,
  output logic               advance_c
);

  localparam int unsigned IW = 2 * WIDTH;

  logic [SETTLE_W-1:0] settle_cnt;

  assign last_c    = (idx == IW'(pair_count(WIDTH) - 1));
  assign advance_c = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      if (step) idx <= idx + IW'(1);
      if (settle_en) settle_cnt <= advance_c ? '0 : settle_cnt + SETTLE_W'(1);
    end
  end

endmodule

// File: rtl/mult_sweep_scorer.sv
// Drives every operand pair into a candidate multiplier and scores its products.
// Optional MULT_SWEEP_MISMATCH_MAP_EN adds a per-pair mismatch bitmap output.
module mult_sweep_scorer
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [WIDTH-1:0]              a_out,
  output logic [WIDTH-1:0]              b_out,
  input  logic [2*WIDTH-1:0]            p_in,
  output logic                          busy,
  output logic                          done,
  output logic [count_width(WIDTH)-1:0] correct_cnt,
  output logic [count_width(WIDTH)-1:0] error_cnt,
  output logic                          first_err_valid,
  output logic [WIDTH-1:0]              first_err_a,
  output logic [WIDTH-1:0]              first_err_b
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
  ,
  output logic [pair_count(WIDTH)-1:0]  mismatch_map
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = count_width(WIDTH);
  // With no settle wait the FSM bounces straight between SAMPLE states.
  localparam state_t FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t        state;
  logic [PW-1:0] idx;
  logic          last_c;
  logic          advance_c;
  logic          accept_c;
  logic          hit_c;

  assign accept_c = (state == IDLE) && start;
  assign hit_c    = (p_in == PW'(golden_mul(32'(a_out), 32'(b_out))));
  assign a_out    = idx[PW-1:WIDTH];
  assign b_out    = idx[WIDTH-1:0];

  mult_sweep_counter #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_c),
    .settle_en(state == SETTLE),
    .step     ((state == SAMPLE) && !last_c),
    .idx      (idx),
    .last_c   (last_c),
    .advance_c(advance_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      correct_cnt     <= '0;
      error_cnt       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
      mismatch_map    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= FIRST;
            busy            <= 1'b1;
            done            <= 1'b0;
            correct_cnt     <= '0;
            error_cnt       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
            mismatch_map    <= '0;
`endif
          end
        end
        SETTLE: begin
          if (advance_c) state <= SAMPLE;
        end
        SAMPLE: begin
          if (hit_c) begin
            correct_cnt <= correct_cnt + CW'(1);
          end else begin
            error_cnt <= error_cnt + CW'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_a     <= a_out;
              first_err_b     <= b_out;
            end
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
            mismatch_map[idx] <= 1'b1;
`endif
          end
          if (last_c) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            state <= FIRST;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sweep_scorer.sv
// Scoreboard bench: two scorers (no settle, settle=2) driven by a behavioural candidate multiplier.
module tb_mult_sweep_scorer;
  import mult_eval_pkg::*;

  localparam int unsigned W  = 2;
  localparam int unsigned N  = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned CW = 5;

  typedef struct {
    int            lat;
    logic [CW-1:0] cor;
    logic [CW-1:0] err;
    logic          fev;
    logic [W-1:0]  fea;
    logic [W-1:0]  feb;
    logic [N-1:0]  map;
  } exp_t;

  exp_t sb[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start   [2];
  logic [W-1:0]  a_o     [2];
  logic [W-1:0]  b_o     [2];
  logic [PW-1:0] p_i     [2];
  logic          busy    [2];
  logic          done    [2];
  logic [CW-1:0] cor     [2];
  logic [CW-1:0] err     [2];
  logic          fev     [2];
  logic [W-1:0]  fea     [2];
  logic [W-1:0]  feb     [2];
  logic [N-1:0]  map     [2];
  int            mode    [2];
  logic          glitch  [2];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  // Candidate multiplier: 0 exact, 1 stuck at zero, 2 wrong only at (2,3), 3 off by one when a==b.
  function automatic logic [PW-1:0] cand(input int md, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    case (md)
      1: p = '0;
      2: if (a == 2'd2 && b == 2'd3) p = '0;
      3: if (a == b) p = p + PW'(1);
      default: ;
    endcase
    return p;
  endfunction

  assign p_i[0] = cand(mode[0], a_o[0], b_o[0]) ^ {PW{glitch[0]}};
  assign p_i[1] = cand(mode[1], a_o[1], b_o[1]) ^ {PW{glitch[1]}};

  mult_sweep_scorer #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]), .p_in(p_i[0]),
    .busy(busy[0]), .done(done[0]), .correct_cnt(cor[0]), .error_cnt(err[0]),
    .first_err_valid(fev[0]), .first_err_a(fea[0]), .first_err_b(feb[0])
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
    , .mismatch_map(map[0])
`endif
  );

  mult_sweep_scorer #(.WIDTH(W), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]), .p_in(p_i[1]),
    .busy(busy[1]), .done(done[1]), .correct_cnt(cor[1]), .error_cnt(err[1]),
    .first_err_valid(fev[1]), .first_err_a(fea[1]), .first_err_b(feb[1])
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
    , .mismatch_map(map[1])
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int md, input int settle);
    exp_t e;
    logic [W-1:0] a, b;
    e.lat = (settle + 1) * N + 1;
    e.cor = '0; e.err = '0; e.fev = 1'b0; e.fea = '0; e.feb = '0; e.map = '0;
    for (int i = 0; i < N; i++) begin
      a = W'(i >> W);
      b = W'(i);
      if (cand(md, a, b) == PW'(a) * PW'(b)) begin
        e.cor = e.cor + CW'(1);
      end else begin
        e.err = e.err + CW'(1);
        e.map[i] = 1'b1;
        if (!e.fev) begin
          e.fev = 1'b1; e.fea = a; e.feb = b;
        end
      end
    end
    return e;
  endfunction

  task automatic check_idle(input int s, input string tag);
    check({tag, "_busy"}, busy[s], 0);
    check({tag, "_done"}, done[s], 0);
    check({tag, "_cor"}, cor[s], 0);
    check({tag, "_err"}, err[s], 0);
    check({tag, "_fev"}, fev[s], 0);
    check({tag, "_ab"}, {a_o[s], b_o[s], fea[s], feb[s]}, 0);
  endtask

  // Called at a negedge; leaves at the negedge where done is first seen high.
  task automatic run_sweep(input int s, input int md, input int settle, input bit poke);
    exp_t e;
    int   cyc;
    mode[s] = md;
    start[s] = 1'b1;
    sb.push_back(model(md, settle));
    @(negedge clk);
    start[s] = 1'b0;
    check("start_busy", busy[s], 1);
    check("start_done_clr", done[s], 0);
    check("start_cnt_clr", {cor[s], err[s], fev[s]}, 0);
    cyc = 0;
    while (!done[s] && cyc < 200) begin
      glitch[s] = (settle > 0) && (((cyc + 1) % (settle + 1)) != 0);
      start[s]  = poke && (cyc + 1 == 5);
      @(negedge clk);
      cyc++;
    end
    glitch[s] = 1'b0;
    start[s]  = 1'b0;
    e = sb.pop_front();
    if (!done[s]) check("done_timeout", 0, 1);
    check("latency", cyc, e.lat);
    check("busy_end", busy[s], 0);
    check("correct_cnt", cor[s], e.cor);
    check("error_cnt", err[s], e.err);
    check("sum_n", cor[s] + err[s], N);
    check("first_err_valid", fev[s], e.fev);
    if (e.fev) check("first_err_ab", {fea[s], feb[s]}, {e.fea, e.feb});
`ifdef MULT_SWEEP_MISMATCH_MAP_EN
    check("mismatch_map", map[s], e.map);
`endif
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    glitch[0] = 1'b0; glitch[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    #1;
    check_idle(0, "rst0");
    check_idle(1, "rst2");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, 0, 0, 1'b0);
    run_sweep(0, 1, 0, 1'b0);   // back-to-back: start while done is high
    run_sweep(0, 1, 0, 1'b0);
    run_sweep(0, 2, 0, 1'b0);
    run_sweep(0, 3, 0, 1'b1);   // stray start at cycle 5 must be ignored

    run_sweep(1, 0, 2, 1'b0);
    run_sweep(1, 2, 2, 1'b0);

    // Abort mid-sweep with asynchronous reset, then rerun cleanly.
    mode[0] = 1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle(0, "abort0");
    check_idle(1, "abort2");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(0, 1, 0, 1'b0);
    run_sweep(0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_sweep_scorer.md
Name: mult_sweep_scorer

Overview:
- Sequential exhaustive evaluator for one candidate combinational multiplier (WIDTH x WIDTH -> 2*WIDTH).
- Upstream role: registers and drives every operand pair {A,B} into the candidate.
- Downstream role: samples the candidate's product, compares it against the exact product, and accumulates correct/error counts.
- Counts feed the RL reward computation; first-failure capture aids debug of correction tables.

Parameters:
- WIDTH, 2, operand width; sweep covers 2^(2*WIDTH) pairs.
- SETTLE_CYCLES, 0, extra wait cycles between driving a pair and sampling p_in (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when not busy.
- a_out  out  WIDTH  registered operand A to candidate.
- b_out  out  WIDTH  registered operand B to candidate.
- p_in  in  2*WIDTH  candidate product (combinational response to a_out/b_out).
- busy  out  1  high while a sweep is in progress.
- done  out  1  level; high from sweep end until next accepted start.
- correct_cnt  out  2*WIDTH+1  pairs with p_in == a_out*b_out.
- error_cnt  out  2*WIDTH+1  pairs with mismatch.
- first_err_valid  out  1  at least one mismatch seen this sweep.
- first_err_a  out  WIDTH  A of lowest-index mismatch.
- first_err_b  out  WIDTH  B of lowest-index mismatch.

Behaviour:
- Reset is asynchronous: all outputs are 0, and the FSM is in IDLE.
- Pair index idx = {a_out, b_out}, with A in the MSBs. idx runs 0 to N-1 ascending, where N = 2^(2*WIDTH).
- FSM states and transitions:
  - IDLE: on start, clear counts, first_err_*, done and the settle counter; set idx = 0; go to SETTLE.
  - SETTLE: hold a_out/b_out for SETTLE_CYCLES cycles, then go to SAMPLE. With SETTLE_CYCLES = 0, SETTLE is skipped: go directly to SAMPLE.
  - SAMPLE: compare p_in against the golden product, computed at full 2*WIDTH width with no truncation.
    - On match, increment correct_cnt.
    - On mismatch, increment error_cnt.
    - If this is the first mismatch, latch first_err_a/b and set first_err_valid.
    - If idx == N-1, go to DONE. Otherwise increment idx and return to SETTLE (or SAMPLE if SETTLE_CYCLES = 0).
  - DONE: assert done, deassert busy, go to IDLE. a_out/b_out keep their last value.
- busy is high in SETTLE and SAMPLE only.
- Latency: (SETTLE_CYCLES+1)*N cycles from start to done rising, plus 1 cycle.
- start while busy is ignored, with no restart.
- start on the cycle done is high clears done and begins a new sweep.
- Invariant at done: correct_cnt + error_cnt == N. Neither counter wraps, since width is 2*WIDTH+1.
- Reset mid-sweep aborts immediately; all outputs return to 0.

Optional Feature:
- Macro: MULT_SWEEP_MISMATCH_MAP_EN.
- Defined: adds output mismatch_map [N-1:0]. Bit idx is set on mismatch at that index; all bits are cleared on accepted start and on rst.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- Shared package mult_eval_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the function golden_mul(a, b);
  - localparam helpers for N and the count width.
- One natural sub-module, mult_sweep_counter: idx plus settle counter, with last/advance outputs. The FSM and scoring stay in the top.

Test Plan:
- Exact WIDTH=2 multiplier on p_in, start -> done after 17 cycles; correct_cnt=16, error_cnt=0, first_err_valid=0.
- p_in tied 0 -> correct_cnt=7, error_cnt=9, first_err_a=1, first_err_b=1, first_err_valid=1.
- Model wrong only at A=2,B=3 (outputs 0), with MULT_SWEEP_MISMATCH_MAP_EN -> error_cnt=1, mismatch_map=16'h0800, first_err=(2,3).
- SETTLE_CYCLES=2, exact model -> done rises 49 cycles after start; the candidate output is checked only in SAMPLE cycles, so counts are unaffected by mid-settle glitches injected on p_in.
- start pulsed at cycle 5 of a sweep -> ignored, done timing unchanged. rst asserted at cycle 8 -> all outputs 0 asynchronously; a fresh start gives correct full results.
- start on the cycle done is high -> done drops next cycle, counts cleared, second sweep gives identical results.
